// File: rtl/axi_dma_reader_if.sv
// AXI3 bundle used by axi_dma_reader; the write channels carry only the
// handshake signals needed to tie them off.
interface axi_ifc;
  logic [3:0]  arid;
  logic [31:0] araddr;
  logic [3:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst;
  logic [1:0]  arlock;
  logic [3:0]  arcache;
  logic [2:0]  arprot;
  logic        arvalid;
  logic        arready;

  logic [3:0]  rid;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rlast;
  logic        rvalid;
  logic        rready;

  logic        awvalid;
  logic        awready;
  logic        wvalid;
  logic        wready;
  logic        bvalid;
  logic        bready;

  modport master (
    output arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
    input  arready,
    input  rid, rdata, rresp, rlast, rvalid,
    output rready,
    output awvalid, wvalid, bready,
    input  awready, wready, bvalid
  );
endinterface

// File: rtl/axi_dma_reader.sv
// AXI3 INCR read-burst master (1-16 words) streaming beats to a local consumer.
// Optional response/rlast checking: define AXI_DMA_READER_RESP_CHECK_EN.
module axi_dma_reader #(
  parameter int unsigned ID_VALUE = 0
) (
  input  logic        clk,
  input  logic        reset,
  axi_ifc.master      m,
  input  logic        start,
  input  logic [31:0] addr,
  input  logic [3:0]  burstlen,
  input  logic        ready,
  output logic [31:0] data,
  output logic        valid,
  output logic        busy,
  output logic        done,
  output logic        error
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] RADDR = 2'd1;
  localparam logic [1:0] RDATA = 2'd2;

  logic [1:0]  state;
  logic [31:0] araddr_r;
  logic [3:0]  arlen_r;
  logic [3:0]  count;
  logic        arvalid_r;
  logic        beat;
  logic        accept_start;

  assign m.arid    = 4'(ID_VALUE);
  assign m.araddr  = araddr_r;
  assign m.arlen   = arlen_r;
  assign m.arsize  = 3'd2;
  assign m.arburst = 2'd1;
  assign m.arlock  = 2'd0;
  assign m.arcache = 4'd0;
  assign m.arprot  = 3'd0;
  assign m.arvalid = arvalid_r;

  assign m.awvalid = 1'b0;
  assign m.wvalid  = 1'b0;
  assign m.bready  = 1'b0;

  // Consumer backpressure goes straight to rready; beats pass through unregistered.
  assign m.rready = (state == RDATA) & ready;
  assign beat     = m.rvalid & m.rready;
  assign data     = m.rdata;
  assign valid    = beat;

  assign accept_start = (state == IDLE) & start;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      arvalid_r <= 1'b0;
      araddr_r  <= '0;
      arlen_r   <= '0;
      count     <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state     <= RADDR;
            busy      <= 1'b1;
            arvalid_r <= 1'b1;
            araddr_r  <= addr;
            arlen_r   <= burstlen;
            count     <= burstlen;
          end
        end
        RADDR: begin
          if (m.arready) begin
            arvalid_r <= 1'b0;
            state     <= RDATA;
          end
        end
        RDATA: begin
          // count, not rlast, decides which beat is the last one
          if (beat) begin
            if (count == 4'd0) begin
              state <= IDLE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end else begin
              count <= count - 4'd1;
            end
          end
        end
        default: begin
          state     <= IDLE;
          busy      <= 1'b0;
          arvalid_r <= 1'b0;
        end
      endcase
    end
  end

`ifdef AXI_DMA_READER_RESP_CHECK_EN
  logic unused_inputs;
  assign unused_inputs = ^{m.rid, m.awready, m.wready, m.bvalid};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      error <= 1'b0;
    end else if (accept_start) begin
      error <= 1'b0;
    end else if (beat && ((m.rresp != 2'b00) || (m.rlast != (count == 4'd0)))) begin
      error <= 1'b1;
    end
  end
`else
  logic unused_inputs;
  assign unused_inputs = ^{m.rid, m.rresp, m.rlast, m.awready, m.wready, m.bvalid, accept_start};
  assign error = 1'b0;
`endif

endmodule

// File: tb/tb_axi_dma_reader.sv
// Directed bench for axi_dma_reader with a simple always-ready AXI read slave.
module tb_axi_dma_reader;
  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [31:0] addr;
  logic [3:0]  burstlen;
  logic        ready;
  logic [31:0] data;
  logic        valid, busy, done, error;

  always #5 clk = ~clk;

  axi_ifc m_if();

  axi_dma_reader #(.ID_VALUE(5)) dut (
    .clk(clk), .reset(reset), .m(m_if),
    .start(start), .addr(addr), .burstlen(burstlen), .ready(ready),
    .data(data), .valid(valid), .busy(busy), .done(done), .error(error)
  );

`ifdef AXI_DMA_READER_RESP_CHECK_EN
  localparam logic EXP_ERR = 1'b1;
`else
  localparam logic EXP_ERR = 1'b0;
`endif

  // Slave side: rvalid gated by r_en, data = rbase + beat index.
  logic        arready_d, r_en, rclr;
  logic [31:0] rbase;
  int          beat_idx;
  int          r_len, bad_resp_beat, early_last_beat;

  assign m_if.arready = arready_d;
  assign m_if.rvalid  = r_en;
  assign m_if.rdata   = rbase + 32'(beat_idx);
  assign m_if.rlast   = (beat_idx == r_len) || (beat_idx == early_last_beat);
  assign m_if.rresp   = (beat_idx == bad_resp_beat) ? 2'b10 : 2'b00;
  assign m_if.rid     = 4'd0;
  assign m_if.awready = 1'b0;
  assign m_if.wready  = 1'b0;
  assign m_if.bvalid  = 1'b0;

  always @(posedge clk) begin
    if (rclr) beat_idx <= 0;
    else if (m_if.rvalid && m_if.rready) beat_idx <= beat_idx + 1;
  end

  // Monitor
  int          ar_cnt = 0, done_cnt = 0;
  logic [31:0] ar_addr_seen;
  logic [3:0]  ar_len_seen;
  logic [31:0] beats[$];

  always @(posedge clk) begin
    if (valid) beats.push_back(data);
    if (done) done_cnt++;
    if (m_if.arvalid && m_if.arready) begin
      ar_cnt++;
      ar_addr_seen = m_if.araddr;
      ar_len_seen  = m_if.arlen;
    end
  end

  int tests = 0, fails = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic ar_phase(input logic [31:0] a, input logic [3:0] len, input int ar_delay,
                          input logic [31:0] base);
    rbase = base; r_len = int'(len); ready = 1'b1; rclr = 1'b1;
    start = 1'b1; addr = a; burstlen = len;
    @(negedge clk);
    start = 1'b0; rclr = 1'b0;
    check("ar_valid_up", m_if.arvalid, 1'b1);
    check("busy_up", busy, 1'b1);
    repeat (ar_delay) @(negedge clk);
    check("ar_addr_stable", m_if.araddr, a);
    check("ar_len_stable", m_if.arlen, len);
    arready_d = 1'b1;
    @(negedge clk);
    arready_d = 1'b0;
    check("ar_valid_down", m_if.arvalid, 1'b0);
  endtask

  task automatic wait_done(output int cyc);
    cyc = 0;
    while (!done && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic run_burst(input logic [31:0] a, input logic [3:0] len, input int ar_delay,
                           input logic [31:0] base, output int cyc);
    ar_phase(a, len, ar_delay, base);
    wait_done(cyc);
  endtask

  int cyc, b0, a0, d0, mirror_err, early_drop;

  initial begin
    reset = 1'b1; start = 1'b0; addr = '0; burstlen = '0; ready = 1'b0;
    arready_d = 1'b0; r_en = 1'b1; rclr = 1'b1; rbase = '0;
    r_len = 0; bad_resp_beat = -1; early_last_beat = -1;
    @(negedge clk);
    @(negedge clk);
    ready = 1'b1;
    #1;
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_error", error, 1'b0);
    check("rst_arvalid", m_if.arvalid, 1'b0);
    check("rst_rready", m_if.rready, 1'b0);
    check("rst_araddr", m_if.araddr, 32'h0);
    check("const_arburst", m_if.arburst, 2'd1);
    check("const_arsize", m_if.arsize, 3'd2);
    check("const_arcache", m_if.arcache, 4'd0);
    check("const_arlock", m_if.arlock, 2'd0);
    check("const_arid", m_if.arid, 4'd5);
    check("tie_write", {m_if.awvalid, m_if.wvalid, m_if.bready}, 3'b000);
    @(negedge clk);
    reset = 1'b0; rclr = 1'b0;
    @(negedge clk);

    // Basic burst: 4 beats, arready delayed 2 cycles
    b0 = beats.size(); a0 = ar_cnt; d0 = done_cnt;
    run_burst(32'h1000_0000, 4'd3, 2, 32'hA0, cyc);
    check("basic_cycles", cyc, 4);
    check("basic_done", done, 1'b1);
    check("basic_busy_falls", busy, 1'b0);
    check("basic_ar_count", ar_cnt - a0, 1);
    check("basic_ar_addr", ar_addr_seen, 32'h1000_0000);
    check("basic_ar_len", ar_len_seen, 4'd3);
    check("basic_beat_count", beats.size() - b0, 4);
    for (int i = 0; i < 4; i++) check("basic_beat", beats[b0 + i], 32'hA0 + i);
    check("basic_error", error, 1'b0);
    @(negedge clk);
    check("basic_done_pulse", done, 1'b0);
    check("basic_done_count", done_cnt - d0, 1);

    // Single beat
    b0 = beats.size();
    run_burst(32'h0000_0040, 4'd0, 0, 32'hDEAD_BEEF, cyc);
    check("single_cycles", cyc, 1);
    check("single_ar_len", ar_len_seen, 4'd0);
    check("single_beat_count", beats.size() - b0, 1);
    check("single_data", beats[b0], 32'hDEAD_BEEF);
    @(negedge clk);

    // Backpressure: ready toggles every cycle over a 16-beat burst
    b0 = beats.size(); mirror_err = 0; early_drop = 0;
    ar_phase(32'h0000_8000, 4'd15, 0, 32'h100);
    cyc = 0;
    while (!done && cyc < 200) begin
      @(negedge clk);
      ready = ~ready;
      #1;
      if (busy && !m_if.arvalid && (m_if.rready !== ready)) mirror_err++;
      if (!busy && !done) early_drop++;
      cyc++;
    end
    check("bp_done", done, 1'b1);
    check("bp_rready_mirror_errs", mirror_err, 0);
    check("bp_busy_early_drop", early_drop, 0);
    check("bp_beat_count", beats.size() - b0, 16);
    for (int i = 0; i < 16; i++) check("bp_beat", beats[b0 + i], 32'h100 + i);
    ready = 1'b1;
    @(negedge clk);

    // Start while busy is ignored; start on the done cycle is accepted
    b0 = beats.size();
    ar_phase(32'h0001_0000, 4'd7, 0, 32'hB00);
    a0 = ar_cnt;
    start = 1'b1; addr = 32'h3000; burstlen = 4'd2;
    @(negedge clk);
    start = 1'b0;
    check("busy_ign_araddr", m_if.araddr, 32'h0001_0000);
    check("busy_ign_busy", busy, 1'b1);
    wait_done(cyc);
    check("busy_first_done", done, 1'b1);
    check("busy_first_beats", beats.size() - b0, 8);
    for (int i = 0; i < 8; i++) check("busy_beat", beats[b0 + i], 32'hB00 + i);
    b0 = beats.size();
    rbase = 32'hC00; r_len = 1; rclr = 1'b1;
    start = 1'b1; addr = 32'h2000; burstlen = 4'd1;
    @(negedge clk);
    start = 1'b0; rclr = 1'b0;
    check("done_start_arvalid", m_if.arvalid, 1'b1);
    check("done_start_araddr", m_if.araddr, 32'h2000);
    check("done_start_arlen", m_if.arlen, 4'd1);
    check("busy_ign_no_extra_ar", ar_cnt - a0, 0);
    arready_d = 1'b1;
    @(negedge clk);
    arready_d = 1'b0;
    wait_done(cyc);
    check("done_start_cycles", cyc, 2);
    check("done_start_beat1", beats[b0 + 1], 32'hC01);
    @(negedge clk);

    // Reset mid-burst after 2 of 8 beats
    b0 = beats.size();
    ar_phase(32'h0000_4000, 4'd7, 0, 32'hD00);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    #1;
    check("rstmid_arvalid", m_if.arvalid, 1'b0);
    check("rstmid_rready", m_if.rready, 1'b0);
    check("rstmid_busy", busy, 1'b0);
    check("rstmid_beats", beats.size() - b0, 2);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    b0 = beats.size();
    run_burst(32'h0000_0500, 4'd2, 1, 32'h700, cyc);
    check("rstmid_after_cycles", cyc, 3);
    check("rstmid_after_ar_addr", ar_addr_seen, 32'h0000_0500);
    for (int i = 0; i < 3; i++) check("rstmid_after_beat", beats[b0 + i], 32'h700 + i);
    @(negedge clk);

    // Response checking: bad rresp on beat 1, then early rlast on beat 0 of 2
    bad_resp_beat = 1;
    run_burst(32'h0000_0600, 4'd3, 0, 32'hE0, cyc);
    check("resp_err_at_done", error, EXP_ERR);
    @(negedge clk);
    check("resp_err_held", error, EXP_ERR);
    bad_resp_beat = -1;
    early_last_beat = 0;
    ar_phase(32'h0000_0700, 4'd1, 0, 32'hF0);
    check("resp_err_cleared", error, 1'b0);
    wait_done(cyc);
    check("rlast_early_err", error, EXP_ERR);
    check("rlast_early_cycles", cyc, 2);
    early_last_beat = -1;
    @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/axi_dma_reader.md
Name: axi_dma_reader

Overview:
- AXI3 read-burst master. It is the read-side companion to the team's DMA writer.
- It issues one INCR burst of 1–16 32-bit words per start request, then streams the returned beats to a local consumer.
- The consumer can stall the stream with a ready input; that stall propagates to rready as backpressure.
- It sits between fabric logic (framebuffer scanout, DMA engines) and an HP/GP AXI port.

Parameters:
- ID_VALUE, 0, constant driven on arid.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- reset  input  1  asynchronous, active-high reset.
- m  interface  axi_ifc.master  AXI master port; only the read channels are used.
- start  input  1  request a burst; sampled only while busy=0.
- addr  input  32  burst start byte address, sampled with start; word-aligned.
- burstlen  input  4  word count minus 1, sampled with start.
- ready  input  1  consumer can accept a word this cycle.
- data  output  32  current read word, equal to m.rdata.
- valid  output  1  a word transfers this cycle, equal to m.rvalid & m.rready.
- busy  output  1  burst in progress.
- done  output  1  one-cycle pulse on the cycle after the final beat is accepted.
- error  output  1  sticky response/protocol error; see Optional Feature.

Behaviour:
- Interface: one clock; reset is asynchronous and active-high.
- Reset values: state=IDLE, busy=0, done=0, error=0, m.arvalid=0, araddr register=0, count=0. m.rready=0 follows combinationally from state.
- Constant read-address fields: arburst=1 (INCR), arsize=2, arcache=0, arlock=0, arid=ID_VALUE. arlen = latched burstlen, zero-extended.
- Write channels tied off: awvalid=0, wvalid=0, bready=0.
- State IDLE:
  - start=1: latch addr into araddr and burstlen into count and arlen.
  - On the next cycle: busy=1, arvalid=1, state=RADDR.
- State RADDR:
  - arvalid stays 1 and araddr/arlen stay stable until the cycle where arvalid & arready.
  - That cycle counts as the handshake; the next cycle has arvalid=0 and state=RDATA.
- State RDATA:
  - m.rready = ready (combinational); data = m.rdata.
  - A beat is accepted when rvalid & rready; valid is asserted that same cycle (zero-latency passthrough).
  - Each accepted beat with count≠0 decrements count.
  - An accepted beat with count=0 is the last beat. Next cycle: state=IDLE, busy=0, done=1 for exactly one cycle.
- rready is 0 in every state except RDATA, so no beats are accepted outside a burst.
- start while busy=1 is ignored; no queuing.
- start on the same cycle done=1: accepted, because state is already IDLE and busy=0. Back-to-back bursts run with one idle cycle between AR handshakes minimum.
- burstlen=0: single beat; arlen=0.
- burstlen=15: 16 beats; count passes 15→0 with no wrap.
- ready held low during RDATA: rready=0 and nothing is accepted; the block waits indefinitely.
- Reset mid-burst: everything returns to reset values immediately. No burst is completed or drained; in-flight R beats are the system's responsibility.
- rlast is ignored for sequencing; count is authoritative.

Optional Feature:
- Macro: AXI_DMA_READER_RESP_CHECK_EN.
- When defined, error is set on any accepted beat where either:
  - rresp≠0, or
  - rlast ≠ (count==0).
- error is sticky until the next accepted start, which clears it on the same edge that sets busy. Sequencing is unaffected.
- When undefined, error is constant 0 and rresp/rlast are unused.

Test Plan:
- Basic burst: reset; start with addr=0x1000_0000, burstlen=3; slave returns 0xA0..0xA3 with arready delayed 2 cycles → exactly one AR with araddr=0x1000_0000, arlen=3; valid pulses 4 times carrying 0xA0..0xA3 in order; done pulses once; busy falls with done.
- Single beat: burstlen=0, rdata=0xDEADBEEF → arlen=0, one valid, done on the next cycle.
- Backpressure: burstlen=15, ready toggled 1/0 every cycle, slave always rvalid → rready mirrors ready; 16 accepted beats in order with no duplicates; busy holds until the 16th beat.
- Start while busy: second start mid-burst → ignored. A start on the done cycle with addr=0x2000 → new AR with araddr=0x2000.
- Reset mid-burst: assert reset after 2 of 8 beats → arvalid=0, rready=0, busy=0 on the same cycle; after release, a new burst completes correctly.
- AXI_DMA_READER_RESP_CHECK_EN:
  - Defined: rresp=2 on beat 1 → error=1, held through done, cleared by the next start.
  - Defined: rlast asserted early on beat 0 of 2 → error=1.
  - Undefined: neither case sets error.
